// File: rtl/io_pkg.sv
// Shared constants and types for the memory-mapped I/O controller.
package io_pkg;

  // I/O register addresses, exact 32-bit match.
  localparam logic [31:0] AddrHex  = 32'hF000_0000;
  localparam logic [31:0] AddrLedr = 32'hF000_0004;
  localparam logic [31:0] AddrKey  = 32'hF000_0010;
  localparam logic [31:0] AddrSw   = 32'hF000_0014;

  // Board I/O widths.
  localparam int unsigned NumKeys = 4;
  localparam int unsigned NumSw   = 10;
  localparam int unsigned HexW    = 16;

  // Field positions inside the KEY register.
  localparam int unsigned KeyStateLsb = 0;
  localparam int unsigned KeyEvtLsb   = 4;

  // Per-bit debouncer state.
  typedef enum logic {
    StStable   = 1'b0,
    StCounting = 1'b1
  } db_state_e;

endpackage

// File: rtl/io_if.sv
// Data-side load/store port between the core and the I/O controller.
interface io_if #(
  parameter int unsigned DBITS = 32
);
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wdata;
  logic             we;
  logic             re;
  logic [DBITS-1:0] rdata;
  logic             io_hit;

  modport master (
    output addr, wdata, we, re,
    input  rdata, io_hit
  );

  modport slave (
    input  addr, wdata, we, re,
    output rdata, io_hit
  );
endinterface

// File: rtl/io_debounce.sv
// Two-flop synchroniser followed by a per-bit counting debouncer.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive
// synchronised samples that all disagree with the current stable value.
module io_debounce
  import io_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          RESET_VAL       = 1'b0,
  parameter bit          INVERT          = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise
);

  localparam int unsigned      CntW    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0]  CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_1_q, sync_2_q;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CntW-1:0]  cnt_q   [WIDTH];
  logic [CntW-1:0]  cnt_d   [WIDTH];
  db_state_e        state_q [WIDTH];
  db_state_e        state_d [WIDTH];

  // Synchroniser chain; reset level matches the pin's idle level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1_q <= {WIDTH{RESET_VAL}};
      sync_2_q <= {WIDTH{RESET_VAL}};
    end else begin
      sync_1_q <= din;
      sync_2_q <= sync_1_q;
    end
  end

  // Active-low inputs are flipped here so downstream logic sees 1 = asserted.
  assign level = sync_2_q ^ {WIDTH{INVERT}};

  // Next-state logic for every bit's debounce FSM and counter.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        StStable: begin
          if (level[i] != stable_q[i]) begin
            state_d[i] = StCounting;
            cnt_d[i]   = CntW'(1);
          end
        end
        StCounting: begin
          if (level[i] == stable_q[i]) begin
            state_d[i] = StStable;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntLast) begin
            stable_d[i] = level[i];
            state_d[i]  = StStable;
            cnt_d[i]    = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end
        end
        default: begin
          state_d[i] = StStable;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Debounce state registers; reset abandons any count in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= StStable;
        cnt_q[i]   <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign dout = stable_q;
  // Rising edge flagged in the same cycle it is committed.
  assign rise = stable_d & ~stable_q;

endmodule

// File: rtl/io_controller.sv
// Memory-mapped KEY/SW/HEX/LEDR block beside data memory. Reads are
// combinational from addr; stores and event clears land at the clock edge.
module io_controller
  import io_pkg::*;
#(
  parameter int unsigned      DBITS           = 32,
  parameter logic [DBITS-1:0] ADDR_KEY        = DBITS'(AddrKey),
  parameter logic [DBITS-1:0] ADDR_SW         = DBITS'(AddrSw),
  parameter logic [DBITS-1:0] ADDR_HEX        = DBITS'(AddrHex),
  parameter logic [DBITS-1:0] ADDR_LEDR       = DBITS'(AddrLedr),
  parameter int unsigned      DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               reset_n,
  io_if.slave                bus,
  input  logic [NumKeys-1:0] key_n,
  input  logic [NumSw-1:0]   sw,
  output logic [NumSw-1:0]   ledr,
  output logic [HexW-1:0]    hex_value
);

  logic [NumKeys-1:0] key_db, key_rise;
  logic [NumSw-1:0]   sw_db, unused_sw_rise;
  logic [NumKeys-1:0] evt_q, evt_d;
  logic [NumSw-1:0]   ledr_q, ledr_d;
  logic [HexW-1:0]    hex_q, hex_d;
  logic               hit_key, hit_sw, hit_hex, hit_ledr;
  logic               key_clr;
  logic [DBITS-1:0]   rdata_mux;
  logic               unused_wdata;

  // Keys idle high on the pins; inverted after sync so 1 = pressed.
  io_debounce #(
    .WIDTH          (NumKeys),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VAL      (1'b1),
    .INVERT         (1'b1)
  ) u_key_db (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (key_n),
    .dout   (key_db),
    .rise   (key_rise)
  );

  io_debounce #(
    .WIDTH          (NumSw),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VAL      (1'b0),
    .INVERT         (1'b0)
  ) u_sw_db (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (sw),
    .dout   (sw_db),
    .rise   (unused_sw_rise)
  );

  assign hit_key  = (bus.addr == ADDR_KEY);
  assign hit_sw   = (bus.addr == ADDR_SW);
  assign hit_hex  = (bus.addr == ADDR_HEX);
  assign hit_ledr = (bus.addr == ADDR_LEDR);

  assign bus.io_hit = hit_key | hit_sw | hit_hex | hit_ledr;

  // Load data mux; addresses are distinct so at most one term is active.
  always_comb begin
    rdata_mux = '0;
    if (hit_key) begin
      rdata_mux[KeyStateLsb +: NumKeys] = key_db;
      rdata_mux[KeyEvtLsb +: NumKeys]   = evt_q;
    end
    if (hit_sw)   rdata_mux[NumSw-1:0] = sw_db;
    if (hit_hex)  rdata_mux[HexW-1:0]  = hex_q;
    if (hit_ledr) rdata_mux[NumSw-1:0] = ledr_q;
  end

  assign bus.rdata = rdata_mux;

  // Next-state for output registers and key events; a new press beats the clear.
  always_comb begin
    key_clr = bus.re & hit_key;
    evt_d   = (key_clr ? '0 : evt_q) | key_rise;
    ledr_d  = (bus.we && hit_ledr) ? bus.wdata[NumSw-1:0] : ledr_q;
    hex_d   = (bus.we && hit_hex)  ? bus.wdata[HexW-1:0]  : hex_q;
  end

  // Output and event registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_q  <= '0;
      ledr_q <= '0;
      hex_q  <= '0;
    end else begin
      evt_q  <= evt_d;
      ledr_q <= ledr_d;
      hex_q  <= hex_d;
    end
  end

  assign ledr      = ledr_q;
  assign hex_value = hex_q;

  // Upper store-data bits are never stored.
  assign unused_wdata = ^bus.wdata[DBITS-1:HexW];

endmodule

// File: tb/tb_io_controller.sv
// Bench for io_controller with a short debounce window.
module tb_io_controller;
  import io_pkg::*;

  localparam int DB = 4;

  logic       clk;
  logic       reset_n;
  logic [3:0] key_n;
  logic [9:0] sw;
  logic [9:0] ledr;
  logic [15:0] hex_value;

  int total = 0;
  int bad   = 0;

  io_if #(.DBITS(32)) bus ();

  io_controller #(
    .DBITS          (32),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .key_n    (key_n),
    .sw       (sw),
    .ledr     (ledr),
    .hex_value(hex_value)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] exp_rdata;
    logic        exp_hit;
    logic [15:0] exp_hex;
    logic [9:0]  exp_ledr;
  } vec_t;

  vec_t vecs[15];

  // Reference model: bits [3:0] = key pressed level, [13:4] = switches.
  logic [13:0] m_s1, m_s2, m_db;
  logic [13:0] m_hist[$];
  logic [3:0]  m_evt;
  logic [9:0]  m_ledr;
  logic [15:0] m_hex;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    bus.we   = 1'b0;
    bus.re   = 1'b0;
    #1;
    chk(name, bus.rdata, exp);
  endtask

  task automatic m_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0;
    m_hist.delete();
    m_evt = '0; m_ledr = '0; m_hex = '0;
  endtask

  // A bit flips once the last DB synchronised samples all disagree with it.
  task automatic m_step();
    logic [13:0] nd;
    logic        all_diff;
    m_hist.push_back(m_s2);
    if (m_hist.size() > DB) m_hist.delete(0);
    nd = m_db;
    if (m_hist.size() == DB) begin
      for (int i = 0; i < 14; i++) begin
        all_diff = 1'b1;
        foreach (m_hist[j]) if (m_hist[j][i] == m_db[i]) all_diff = 1'b0;
        if (all_diff) nd[i] = ~m_db[i];
      end
    end
    if (bus.re && bus.addr == AddrKey) m_evt = '0;
    m_evt = m_evt | (nd[3:0] & ~m_db[3:0]);
    if (bus.we && bus.addr == AddrHex)  m_hex  = bus.wdata[15:0];
    if (bus.we && bus.addr == AddrLedr) m_ledr = bus.wdata[9:0];
    m_db = nd;
    m_s2 = m_s1;
    m_s1 = {sw, ~key_n};
  endtask

  function automatic logic [31:0] m_rdata(input logic [31:0] a);
    case (a)
      AddrKey:  return {24'b0, m_evt, m_db[3:0]};
      AddrSw:   return {22'b0, m_db[13:4]};
      AddrHex:  return {16'b0, m_hex};
      AddrLedr: return {22'b0, m_ledr};
      default:  return 32'h0;
    endcase
  endfunction

  function automatic logic m_hit(input logic [31:0] a);
    return (a == AddrKey) || (a == AddrSw) || (a == AddrHex) || (a == AddrLedr);
  endfunction

  initial begin
    vecs[0]  = '{AddrHex,       32'hDEADBEEF, 1'b1, 1'b0, 32'h0,      1'b1, 16'h0,    10'h0};
    vecs[1]  = '{AddrHex,       32'h0,        1'b0, 1'b1, 32'h0000BEEF, 1'b1, 16'hBEEF, 10'h0};
    vecs[2]  = '{AddrLedr,      32'hFFFFFFFF, 1'b1, 1'b0, 32'h0,      1'b1, 16'hBEEF, 10'h0};
    vecs[3]  = '{AddrLedr,      32'h0,        1'b0, 1'b1, 32'h3FF,    1'b1, 16'hBEEF, 10'h3FF};
    vecs[4]  = '{32'hF0000008,  32'h12345678, 1'b1, 1'b0, 32'h0,      1'b0, 16'hBEEF, 10'h3FF};
    vecs[5]  = '{AddrHex,       32'h0,        1'b0, 1'b0, 32'hBEEF,   1'b1, 16'hBEEF, 10'h3FF};
    vecs[6]  = '{AddrKey,       32'hFF,       1'b1, 1'b1, 32'h0,      1'b1, 16'hBEEF, 10'h3FF};
    vecs[7]  = '{AddrSw,        32'h3FF,      1'b1, 1'b0, 32'h0,      1'b1, 16'hBEEF, 10'h3FF};
    vecs[8]  = '{AddrKey,       32'h0,        1'b0, 1'b1, 32'h0,      1'b1, 16'hBEEF, 10'h3FF};
    vecs[9]  = '{AddrLedr,      32'h155,      1'b1, 1'b1, 32'h3FF,    1'b1, 16'hBEEF, 10'h3FF};
    vecs[10] = '{AddrLedr,      32'h0,        1'b0, 1'b0, 32'h155,    1'b1, 16'hBEEF, 10'h155};
    vecs[11] = '{32'h00000000,  32'h0,        1'b0, 1'b1, 32'h0,      1'b0, 16'hBEEF, 10'h155};
    vecs[12] = '{32'hF000000C,  32'hFFFF,     1'b1, 1'b0, 32'h0,      1'b0, 16'hBEEF, 10'h155};
    vecs[13] = '{AddrHex,       32'h1234A5A5, 1'b1, 1'b0, 32'hBEEF,   1'b1, 16'hBEEF, 10'h155};
    vecs[14] = '{AddrHex,       32'h0,        1'b0, 1'b0, 32'hA5A5,   1'b1, 16'hA5A5, 10'h155};

    reset_n = 1'b0;
    key_n = 4'hF; sw = '0;
    bus.addr = '0; bus.wdata = '0; bus.we = 1'b0; bus.re = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Table-driven store/load vectors.
    foreach (vecs[i]) begin
      bus.addr = vecs[i].addr; bus.wdata = vecs[i].wdata;
      bus.we = vecs[i].we; bus.re = vecs[i].re;
      #1;
      chk($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_hit", i), {31'b0, bus.io_hit}, {31'b0, vecs[i].exp_hit});
      chk($sformatf("vec%0d_hex", i), {16'b0, hex_value}, {16'b0, vecs[i].exp_hex});
      chk($sformatf("vec%0d_ledr", i), {22'b0, ledr}, {22'b0, vecs[i].exp_ledr});
      tick();
    end

    // Switch debounce latency: accepted exactly after edge 6.
    sw = 10'h3FF;
    for (int k = 1; k <= 6; k++) begin
      tick();
      read_chk($sformatf("sw_lat_e%0d", k), AddrSw, (k == 6) ? 32'h3FF : 32'h0);
    end

    // Asynchronous reset mid-cycle, checked before any clock edge.
    #1;
    reset_n = 1'b0; key_n = 4'hF; sw = '0;
    #1;
    chk("rst_ledr", {22'b0, ledr}, 32'h0);
    chk("rst_hex", {16'b0, hex_value}, 32'h0);
    read_chk("rst_key", AddrKey, 32'h0);
    read_chk("rst_sw", AddrSw, 32'h0);
    tick();
    reset_n = 1'b1;

    // Three-cycle glitch on sw[0] must be rejected.
    sw = 10'h001;
    for (int k = 0; k < 3; k++) begin
      tick();
      read_chk("glitch_sw", AddrSw, 32'h0);
    end
    sw = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      read_chk("glitch_sw", AddrSw, 32'h0);
    end

    // Key 2 press, read-clear, release.
    key_n = 4'b1011;
    for (int k = 1; k <= 6; k++) begin
      tick();
      read_chk($sformatf("key2_e%0d", k), AddrKey, (k == 6) ? 32'h44 : 32'h0);
    end
    bus.addr = AddrKey; bus.re = 1'b1; bus.we = 1'b0;
    #1;
    chk("key2_rc_rdata", bus.rdata, 32'h44);
    tick();
    read_chk("key2_after_clr", AddrKey, 32'h04);
    key_n = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      tick();
      read_chk($sformatf("key2_rel_e%0d", k), AddrKey, (k == 6) ? 32'h0 : 32'h04);
    end

    // Set/clear collision: KEY1 press lands with a clear of the KEY0 event.
    key_n = 4'b1110;
    repeat (6) tick();
    read_chk("key0_press", AddrKey, 32'h11);
    key_n = 4'hF;
    repeat (6) tick();
    read_chk("key0_rel", AddrKey, 32'h10);
    key_n = 4'b1101;
    for (int k = 1; k <= 5; k++) begin
      tick();
      read_chk("coll_pre", AddrKey, 32'h10);
    end
    bus.addr = AddrKey; bus.re = 1'b1;
    #1;
    chk("coll_rc_rdata", bus.rdata, 32'h10);
    tick();
    read_chk("coll_result", AddrKey, 32'h22);

    // Reset during a count: debouncing restarts from scratch.
    key_n = 4'b1110;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    read_chk("midcnt_rst", AddrKey, 32'h0);
    tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      read_chk($sformatf("midcnt_e%0d", k), AddrKey, (k == 6) ? 32'h11 : 32'h0);
    end

    // Randomised traffic against the reference model.
    reset_n = 1'b0; m_reset();
    key_n = 4'hF; sw = '0;
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      int unsigned sel;
      int unsigned idx;
      sel = $urandom_range(0, 7);
      case (sel)
        0, 6, 7: bus.addr = AddrKey;
        1:       bus.addr = AddrSw;
        2:       bus.addr = AddrHex;
        3:       bus.addr = AddrLedr;
        4:       bus.addr = 32'hF0000008;
        default: bus.addr = $urandom;
      endcase
      bus.wdata = $urandom;
      bus.we    = ($urandom_range(0, 3) == 0);
      bus.re    = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, 13);
        if (idx < 4) key_n[idx] = ~key_n[idx];
        else sw[idx-4] = ~sw[idx-4];
      end
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        m_reset();
      end else begin
        reset_n = 1'b1;
      end
      #1;
      chk("rnd_rdata", bus.rdata, m_rdata(bus.addr));
      chk("rnd_hit", {31'b0, bus.io_hit}, {31'b0, m_hit(bus.addr)});
      chk("rnd_ledr", {22'b0, ledr}, {22'b0, m_ledr});
      chk("rnd_hex", {16'b0, hex_value}, {16'b0, m_hex});
      @(posedge clk);
      if (reset_n) m_step();
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_controller.md
# io_controller

Memory-mapped I/O controller for the single-cycle processor. It decodes data-side load/store accesses to the KEY, SW, HEX and LEDR addresses and holds the output registers that drive the LEDs and the seven-segment display. It synchronises and debounces the board switches and keys, and latches key-press events until software consumes them. It sits beside data memory; the top level selects its `rdata` onto the register-file I/O input whenever `io_hit` is high.

## Interface
- `DBITS`, 32, data and address width.
- `ADDR_KEY`, 32'hF0000010, key state/event register (read; read-to-clear events).
- `ADDR_SW`, 32'hF0000014, debounced switch register (read-only).
- `ADDR_HEX`, 32'hF0000000, 16-bit seven-segment value (read/write).
- `ADDR_LEDR`, 32'hF0000004, 10-bit red LED register (read/write).
- `DEBOUNCE_CYCLES`, 500000, consecutive stable cycles required to accept a new input level (≥2).
- `clk`  in  1  single system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `addr`  in  DBITS  data-side byte address.
- `wdata`  in  DBITS  store data.
- `we`  in  1  store strobe.
- `re`  in  1  load strobe.
- `rdata`  out  DBITS  load data, combinational from `addr`.
- `io_hit`  out  1  `addr` matches one of the four I/O addresses (combinational).
- `key_n`  in  4  raw KEY pins, active-low, asynchronous.
- `sw`  in  10  raw SW pins, asynchronous.
- `ledr`  out  10  LED register.
- `hex_value`  out  16  four nibbles; the top level feeds these to SevenSeg HEX3..HEX0.

## Operation
- Address match is an exact 32-bit compare. Non-matching addresses: `io_hit`=0, `rdata`=0, and stores have no effect.
- Input path: each input bit passes through a 2-flop synchroniser and then a debouncer. Key bits are inverted after the synchroniser, so 1 = pressed.
- Debouncer per bit has two states, STABLE and COUNTING, with counter `cnt`.
  - STABLE: sync==stable. `cnt`=0.
  - On a mismatch, move to COUNTING. `cnt` increments on each mismatch cycle.
  - Any match before the terminal count returns the bit to STABLE and clears `cnt`.
  - At the mismatch where `cnt`==DEBOUNCE_CYCLES-1: stable←sync, `cnt`←0, state→STABLE.
- Key events: `evt[i]` is set on the edge where debounced key i goes 0→1.
- Reads:
  - ADDR_KEY → {24'b0, evt[3:0], key_db[3:0]}.
  - ADDR_SW → {22'b0, sw_db}.
  - ADDR_HEX → {16'b0, hex_value}.
  - ADDR_LEDR → {22'b0, ledr}.
- Read-to-clear: at the edge of a cycle with `re` and `addr`==ADDR_KEY, evt bits that were set are cleared. If a bit's set condition occurs in the same cycle, set wins and that event is retained.
- Writes:
  - ADDR_HEX: hex_value←wdata[15:0].
  - ADDR_LEDR: ledr←wdata[9:0].
  - Writes to ADDR_KEY and ADDR_SW are ignored and do not clear events.
- `re` and `we` high together: `rdata` shows the pre-write value, and the write lands at the edge.

## Timing
- Reset (asynchronous, `reset_n`=0):
  - `ledr`=0, `hex_value`=0, `evt`=0.
  - Key synchronisers =1 (released). Switch synchronisers =0.
  - Debounced key and switch values =0. All counters =0, all debouncers in STABLE.
- Reset asserted mid-count: the count is abandoned. After release, debouncing restarts from the reset values.
- `rdata` and `io_hit` have zero latency. Stores are visible on `ledr`/`hex_value` one edge after the `we` cycle.
- Input latency: a pin level held from sampling edge 1 onward appears on the debounced value after edge DEBOUNCE_CYCLES+2. The `evt` bit sets on that same edge, and a read of ADDR_KEY reflects it in the following cycle.
- A glitch shorter than DEBOUNCE_CYCLES cycles (after synchronisation) never changes the debounced value.
- No stalls and no handshake beyond the strobes: every access completes in the cycle it is presented.

## Structure
- Shared package `io_pkg` holds:
  - the four address constants;
  - the debouncer state encoding (STABLE, COUNTING);
  - the register field positions (KEY state [3:0], KEY events [7:4]).
- Sub-module `io_debounce`, parameterised by WIDTH and DEBOUNCE_CYCLES:
  - contains the synchroniser, the per-bit FSM and the counters;
  - has a RESET_VAL parameter for the synchroniser reset level;
  - is instantiated twice (keys WIDTH=4, RESET_VAL=1; switches WIDTH=10, RESET_VAL=0).
- `cnt` width is $clog2(DEBOUNCE_CYCLES).

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: assert `reset_n`=0 mid-cycle → `ledr`=0, `hex_value`=0, a read of ADDR_KEY returns 0 and a read of ADDR_SW returns 0, all immediately, without a clock edge.
- Store/load: `we` to ADDR_HEX with 32'hDEADBEEF → `hex_value`=16'hBEEF after one edge; a read of ADDR_HEX returns 32'h0000BEEF. `we` to 32'hF0000008 → no change, `io_hit`=0.
- Switch debounce: sw=10'h3FF held → a read of ADDR_SW becomes 32'h3FF exactly after edge 6. A 3-cycle pulse sw[0]=1 → ADDR_SW stays 0.
- Key event: key_n[2]=0 held → the ADDR_KEY read becomes 32'h44. Read with `re` → next read returns 32'h04. Release → 32'h00.
- Set/clear collision: the debounced press of KEY1 lands on the same edge as a read-clear of an existing KEY0 event → result 32'h22 (KEY0 event cleared, KEY1 event and state set).
- Reset mid-count: key_n[0] low for 3 cycles, then `reset_n` pulse, then held low → the debounced value sets only 6 edges after reset release.
